// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, funct codes,
// ALU and mux-select encodings, and the controller state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_MEM_WB,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_TRAP
  } state_e;

  // R-type functs the datapath ALU can execute; anything else traps.
  function automatic logic is_rtype_funct(input logic [5:0] funct);
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags when the wait has run
// for MEM_TIMEOUT cycles.
module mips_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic incr,
  output logic expired
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == CW'(MEM_TIMEOUT));

  // Holding at the limit keeps the compare true until the FSM leaves the wait state.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (incr && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/write-back,
// drives the shared-memory datapath, traps on illegal ops or memory timeouts.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int HAS_BNE     = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         Inst,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               err,
  output logic [CNT_W-1:0]   instr_cnt
);

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   instr_cnt_q;
  logic [CNT_W-1:0]   instr_cnt_d;
  logic               in_wait_state;
  logic               wait_expired;
  logic [2:0]         alu_op;

  assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                         (state_q == S_MEM_WR);

  // Any state change restarts the count, so each wait state starts from zero.
  mips_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_d != state_q),
    .incr   (in_wait_state && !mem_ready),
    .expired(wait_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Only final states ever return to FETCH, so any re-entry retires one instruction.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)         state_d = S_DECODE;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (Inst)
          OP_RTYPE: begin
            if (Funct == FN_JR)             state_d = S_JR;
            else if (is_rtype_funct(Funct)) state_d = S_EXEC_R;
            else                            state_d = S_TRAP;
          end
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          OP_BEQ:                           state_d = S_BRANCH;
          OP_BNE:                           state_d = (HAS_BNE != 0) ? S_BRANCH : S_TRAP;
          OP_J:                             state_d = S_JUMP;
          OP_JAL:                           state_d = S_JAL;
          default:                          state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (Inst == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)         state_d = S_MEM_WB;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready)         state_d = S_FETCH;
        else if (wait_expired) state_d = S_TRAP;
      end
      S_EXEC_R: state_d = S_R_WB;
      S_EXEC_I: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = WB_ALUOUT;
    ALUSrcB     = SRCB_REGB;
    PCSrc       = PCSRC_ALU;
    alu_op      = ALU_ADD;
    err         = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = WB_MDR;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        alu_op  = ALU_RTYPE;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (Inst)
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_I_WB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        alu_op      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = PCSRC_ALUOUT;
        BranchNe    = (Inst == OP_BNE);
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSrc    = PCSRC_JUMP;
        RegWrite = 1'b1;
        RegDst   = REGDST_RA;
        MemtoReg = WB_PC;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_REGA;
      end
      S_TRAP:  err = 1'b1;
      default: err = 1'b1;
    endcase
  end

  assign ALUop     = ALUOP_W'(alu_op);
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: two instances (bne enabled with short timeout and 4-bit
// counter, bne disabled with defaults) checked every cycle against an
// instruction-sequence model, plus hand-computed literal checks.
module tb_mips_mc_ctrl;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADDI = 6'b001000;
  localparam logic [5:0] T_SLTI = 6'b001010;
  localparam logic [5:0] T_ANDI = 6'b001100;
  localparam logic [5:0] T_ORI  = 6'b001101;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_JAL  = 6'b000011;
  localparam logic [5:0] T_ADD_FN = 6'b100000;
  localparam logic [5:0] T_JR_FN  = 6'b001000;
  localparam logic [5:0] T_BAD    = 6'b111111;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4,
                 C_J = 5, C_JAL = 6, C_JR = 7, C_ILL = 8;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                ir_write, reg_write, alu_src_a;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic       err;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] Inst = '0;
  logic [5:0] Funct = '0;
  logic mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic PCWrite_a, PCWriteCond_a, BranchNe_a, IorD_a, MemRead_a, MemWrite_a;
  logic IRWrite_a, RegWrite_a, ALUSrcA_a, err_a;
  logic [1:0] RegDst_a, MemtoReg_a, ALUSrcB_a, PCSrc_a;
  logic [2:0] ALUop_a;
  logic [3:0] instr_cnt_a;

  logic PCWrite_b, PCWriteCond_b, BranchNe_b, IorD_b, MemRead_b, MemWrite_b;
  logic IRWrite_b, RegWrite_b, ALUSrcA_b, err_b;
  logic [1:0] RegDst_b, MemtoReg_b, ALUSrcB_b, PCSrc_b;
  logic [2:0] ALUop_b;
  logic [31:0] instr_cnt_b;

  outs_t act_a, act_b;
  assign act_a = {PCWrite_a, PCWriteCond_a, BranchNe_a, IorD_a, MemRead_a, MemWrite_a,
                  IRWrite_a, RegWrite_a, ALUSrcA_a, RegDst_a, MemtoReg_a, ALUSrcB_a,
                  PCSrc_a, ALUop_a, err_a};
  assign act_b = {PCWrite_b, PCWriteCond_b, BranchNe_b, IorD_b, MemRead_b, MemWrite_b,
                  IRWrite_b, RegWrite_b, ALUSrcA_b, RegDst_b, MemtoReg_b, ALUSrcB_b,
                  PCSrc_b, ALUop_b, err_b};

  always #5 clk = ~clk;

  mips_mc_ctrl #(.ALUOP_W(3), .HAS_BNE(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .Inst(Inst), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite_a), .PCWriteCond(PCWriteCond_a), .BranchNe(BranchNe_a),
    .IorD(IorD_a), .MemRead(MemRead_a), .MemWrite(MemWrite_a), .IRWrite(IRWrite_a),
    .RegWrite(RegWrite_a), .ALUSrcA(ALUSrcA_a), .RegDst(RegDst_a),
    .MemtoReg(MemtoReg_a), .ALUSrcB(ALUSrcB_a), .PCSrc(PCSrc_a), .ALUop(ALUop_a),
    .err(err_a), .instr_cnt(instr_cnt_a)
  );

  mips_mc_ctrl #(.ALUOP_W(3), .HAS_BNE(0), .MEM_TIMEOUT(16), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .Inst(Inst), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite_b), .PCWriteCond(PCWriteCond_b), .BranchNe(BranchNe_b),
    .IorD(IorD_b), .MemRead(MemRead_b), .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
    .RegWrite(RegWrite_b), .ALUSrcA(ALUSrcA_b), .RegDst(RegDst_b),
    .MemtoReg(MemtoReg_b), .ALUSrcB(ALUSrcB_b), .PCSrc(PCSrc_b), .ALUop(ALUop_b),
    .err(err_b), .instr_cnt(instr_cnt_b)
  );

  // Instruction class from the opcode/funct rules of the ISA subset.
  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn, input bit has_bne);
    case (op)
      T_R: begin
        if (fn == T_JR_FN) return C_JR;
        case (fn)
          6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
          6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
          6'b000011: return C_R;
          default: return C_ILL;
        endcase
      end
      T_LW: return C_LW;
      T_SW: return C_SW;
      T_ADDI, T_SLTI, T_ANDI, T_ORI: return C_I;
      T_BEQ: return C_BR;
      T_BNE: return has_bne ? C_BR : C_ILL;
      T_J:   return C_J;
      T_JAL: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // Total cycles the instruction takes with zero-wait memory.
  function automatic int seq_len(input int cls);
    case (cls)
      C_R, C_I, C_SW: return 4;
      C_LW:           return 5;
      C_ILL:          return 2;
      default:        return 3;
    endcase
  endfunction

  function automatic bit is_wait_step(input int cls, input int step);
    return (step == 0) || (((cls == C_LW) || (cls == C_SW)) && (step == 3));
  endfunction

  // Expected outputs for cycle 'step' of an instruction of class 'cls'.
  function automatic outs_t exp_out(input int cls, input int step, input logic mr,
                                    input bit trap, input logic [5:0] op);
    outs_t o = '0;
    if (trap) begin
      o.err = 1'b1;
      return o;
    end
    if (step == 0) begin
      o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr;
      return o;
    end
    if (step == 1) begin
      o.alu_src_b = 2'b11;
      return o;
    end
    case (cls)
      C_R: if (step == 2) begin o.alu_src_a = 1'b1; o.alu_op = 3'b010; end
           else begin o.reg_write = 1'b1; o.reg_dst = 2'b01; end
      C_I: if (step == 2) begin
             o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
             o.alu_op = (op == T_SLTI) ? 3'b101 : (op == T_ANDI) ? 3'b011 :
                        (op == T_ORI) ? 3'b100 : 3'b000;
           end else o.reg_write = 1'b1;
      C_LW: if (step == 2) begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            else if (step == 3) begin o.mem_read = 1'b1; o.iord = 1'b1; end
            else begin o.reg_write = 1'b1; o.mem_to_reg = 2'b01; end
      C_SW: if (step == 2) begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            else begin o.mem_write = 1'b1; o.iord = 1'b1; end
      C_BR: begin
        o.alu_src_a = 1'b1; o.alu_op = 3'b001; o.pc_write_cond = 1'b1;
        o.pc_src = 2'b01; o.branch_ne = (op == T_BNE);
      end
      C_J:   begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
      C_JAL: begin
        o.pc_write = 1'b1; o.pc_src = 2'b10; o.reg_write = 1'b1;
        o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
      end
      C_JR:  begin o.pc_write = 1'b1; o.pc_src = 2'b11; end
      default: ;
    endcase
    return o;
  endfunction

  // Model state per instance: index 0 -> dut_a, index 1 -> dut_b.
  int          m_step [2];
  int          m_wait [2];
  bit          m_trap [2];
  logic [31:0] m_cnt  [2];
  bit          m_valid = 1'b0;

  always @(posedge clk) begin : model
    int st, wt, cls, lim;
    bit tr;
    logic [31:0] cn;
    for (int k = 0; k < 2; k++) begin
      st = m_step[k]; wt = m_wait[k]; tr = m_trap[k]; cn = m_cnt[k];
      lim = (k == 0) ? 4 : 16;
      if (rst) begin
        st = 0; wt = 0; tr = 1'b0; cn = '0;
      end else if (!tr) begin
        cls = cls_of(Inst, Funct, k == 0);
        if (is_wait_step(cls, st) && !mem_ready) begin
          if (wt == lim) tr = 1'b1;
          else wt = wt + 1;
        end else if ((cls == C_ILL) && (st == 1)) begin
          tr = 1'b1;
        end else begin
          wt = 0;
          if (st + 1 == seq_len(cls)) begin
            st = 0;
            cn = cn + 32'd1;
          end else begin
            st = st + 1;
          end
        end
      end
      m_step[k] <= st; m_wait[k] <= wt; m_trap[k] <= tr; m_cnt[k] <= cn;
    end
    if (rst) m_valid <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("outs_a", 32'(act_a),
        32'(exp_out(cls_of(Inst, Funct, 1'b1), m_step[0], mem_ready, m_trap[0], Inst)));
      checkOutput("outs_b", 32'(act_b),
        32'(exp_out(cls_of(Inst, Funct, 1'b0), m_step[1], mem_ready, m_trap[1], Inst)));
      checkOutput("cnt_a", {28'd0, instr_cnt_a}, {28'd0, m_cnt[0][3:0]});
      checkOutput("cnt_b", instr_cnt_b, m_cnt[1]);
    end
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic mr);
    Inst = op;
    Funct = fn;
    mem_ready = mr;
  endtask

  task automatic nextCycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    applyStimulus(T_R, T_ADD_FN, 1'b1);
    nextCycle(2);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_err", {31'd0, err_a}, 32'd0);
    checkOutput("reset_cnt", {28'd0, instr_cnt_a}, 32'd0);
    checkOutput("add_irwrite_c0", {31'd0, IRWrite_a}, 32'd1);
    nextCycle(3);
    @(negedge clk);
    checkOutput("add_regwrite_c3", {31'd0, RegWrite_a}, 32'd1);
    checkOutput("add_regdst_c3", {30'd0, RegDst_a}, 32'd1);
    nextCycle(1);
    @(negedge clk);
    checkOutput("add_cnt", {28'd0, instr_cnt_a}, 32'd1);

    applyStimulus(T_LW, 6'd0, 1'b1);
    nextCycle(3);
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("lw_wait_first", {30'd0, MemRead_a, IorD_a}, 32'd3);
    nextCycle(2);
    @(negedge clk);
    checkOutput("lw_wait_last", {30'd0, MemRead_a, IorD_a}, 32'd3);
    nextCycle(1);
    mem_ready = 1'b1;
    nextCycle(1);
    @(negedge clk);
    checkOutput("lw_memwb", {29'd0, RegWrite_a, MemtoReg_a}, 32'd5);
    nextCycle(1);

    applyStimulus(T_BNE, 6'd0, 1'b1);
    nextCycle(2);
    @(negedge clk);
    checkOutput("bne_branchne", {30'd0, BranchNe_a, PCWriteCond_a}, 32'd3);
    checkOutput("bne_disabled_err", {31'd0, err_b}, 32'd1);
    nextCycle(1);

    applyStimulus(T_JAL, 6'd0, 1'b1);
    nextCycle(2);
    @(negedge clk);
    checkOutput("jal_c2", {27'd0, PCWrite_a, RegDst_a, MemtoReg_a}, 32'b1_10_10);
    nextCycle(1);

    applyStimulus(T_R, T_JR_FN, 1'b1);
    nextCycle(2);
    @(negedge clk);
    checkOutput("jr_pcsrc", {30'd0, PCSrc_a}, 32'd3);
    nextCycle(1);
    @(negedge clk);
    checkOutput("cnt_after_jr", {28'd0, instr_cnt_a}, 32'd5);

    applyStimulus(T_SLTI, 6'd0, 1'b1);
    nextCycle(2);
    @(negedge clk);
    checkOutput("slti_aluop", {29'd0, ALUop_a}, 32'd5);
    nextCycle(2);
    applyStimulus(T_ADDI, 6'd0, 1'b1); nextCycle(4);
    applyStimulus(T_ANDI, 6'd0, 1'b1); nextCycle(4);
    applyStimulus(T_ORI, 6'd0, 1'b1);  nextCycle(4);
    applyStimulus(T_BEQ, 6'd0, 1'b1);  nextCycle(3);
    applyStimulus(T_J, 6'd0, 1'b1);    nextCycle(3);
    applyStimulus(T_SW, 6'd0, 1'b1);
    nextCycle(3);
    mem_ready = 1'b0;
    nextCycle(2);
    mem_ready = 1'b1;
    nextCycle(1);
    applyStimulus(T_ADDI, 6'd0, 1'b0);
    nextCycle(2);
    mem_ready = 1'b1;
    nextCycle(4);

    applyStimulus(T_J, 6'd0, 1'b0);
    nextCycle(4);
    @(negedge clk);
    checkOutput("timeout_not_yet", {31'd0, err_a}, 32'd0);
    nextCycle(1);
    @(negedge clk);
    checkOutput("timeout_trap", {31'd0, err_a}, 32'd1);
    nextCycle(1);
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("trap_sticky", {31'd0, err_a}, 32'd1);

    rst = 1'b1;
    nextCycle(1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_clears_err", {31'd0, err_a}, 32'd0);
    checkOutput("rst_clears_cnt", {28'd0, instr_cnt_a}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(T_J, 6'd0, 1'b1);
      nextCycle(3);
    end
    @(negedge clk);
    checkOutput("cnt_wrap", {28'd0, instr_cnt_a}, 32'd1);
    checkOutput("cnt_nowrap_b", instr_cnt_b, 32'd17);

    applyStimulus(T_ADDI, 6'd0, 1'b0);
    nextCycle(4);
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("ready_at_limit", {31'd0, IRWrite_a}, 32'd1);
    nextCycle(1);
    @(negedge clk);
    checkOutput("ready_at_limit_decode", {29'd0, err_a, ALUSrcB_a}, 32'd3);
    nextCycle(3);

    applyStimulus(T_R, T_BAD, 1'b1);
    nextCycle(2);
    @(negedge clk);
    checkOutput("bad_funct_trap", {30'd0, err_a, err_b}, 32'd3);

    rst = 1'b1;
    nextCycle(1);
    rst = 1'b0;
    applyStimulus(T_BAD, 6'd0, 1'b1);
    nextCycle(2);
    @(negedge clk);
    checkOutput("bad_opcode_trap", {30'd0, err_a, err_b}, 32'd3);
    nextCycle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
